control_unit: RTL and testbench
===============================

# control_unit

Multi-cycle control unit for the cs147sec05 32-bit processor. Consumes `INSTRUCTION` and `ZERO` from the data path and drives the 32-bit `CTRL` word back into it, sequencing every instruction through five states. It sits directly upstream of the data path's control input.

## Interface
- No parameters.
- `CLK` in 1: system clock; all state updates occur on its rising edge.
- `RST` in 1: asynchronous, active-low reset.
- `INSTRUCTION` in 32: current IR contents. Fields: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0], imm[15:0], addr[25:0].
- `ZERO` in 1: ALU zero flag.
- `CTRL` out 32: data-path control word. Bit map:
  - 0 pc_load, 1 pc_sel_1, 2 pc_sel_2, 3 pc_sel_3, 4 ir_load, 5 mem_r, 6 mem_w, 7 r1_sel_1
  - 8 reg_r, 9 reg_w, 10 wa_sel_1, 11 wa_sel_2, 12 wa_sel_3, 13 wd_sel_1, 14 wd_sel_2, 15 wd_sel_3
  - 16 sp_load, 17 op1_sel_1, 18 op2_sel_1, 19 op2_sel_2, 20 op2_sel_3, 21 op2_sel_4
  - 25:22 alu_oprn, 26 ma_sel_1, 27 ma_sel_2, 28 md_sel_1
  - 31:29 always 0
- `STATE` out 3: current state encoding, for debug and verification.

## Operation
- State register cycles IF(0) → ID(1) → EXE(2) → MEM(3) → WB(4) → IF. Every instruction takes all five states.
- `CTRL` is a combinational function of the state, `INSTRUCTION`, and `zero_q`. Any bit not listed for a state is 0.
- IF: ma_sel_2, mem_r, ir_load. IR captures memory data at the IF→ID edge.
- ID: reg_r.
- EXE: reg_r plus the operand selects and alu_oprn for the instruction. These bits are held through MEM and WB.
- MEM: adds the memory bits below.
- WB: adds reg_w, sp_load, and pc_load as below. mem_w is never asserted in WB.
- PC source:
  - Normal: pc_sel_1=1, pc_sel_2=0, pc_sel_3=1.
  - jr: pc_sel_1=0, pc_sel_2=0, pc_sel_3=1.
  - Taken branch: pc_sel_2=1, pc_sel_3=1.
  - jmp / jal: pc_sel_1=0, pc_sel_2=0, pc_sel_3=0.
- ALU codes: add 1, sub 2, mul 3, shr 4, shl 5, and 6, or 7, nor 8, slt 9.
- R-type (opcode 0):
  - add 20h, sub 22h, mul 2Ch, and 24h, or 25h, nor 27h, slt 2Ah: op2_sel_4=1; write rd (wa_sel_3=1, wd_sel_3=1).
  - sll 01h / srl 02h: op2_sel_3=1, op2_sel_1=1, shl / shr; write rd.
  - jr 08h: no register write.
- I-type:
  - addi 08h, muli 1Dh, slti 0Ah, lw 23h, sw 2Bh: op2_sel_2=1 (sign-extended immediate).
  - andi 0Ch, ori 0Dh: zero-extended immediate.
  - Results are written to rt (wa_sel_3=1, wa_sel_1=1, wd_sel_3=1).
  - lui 0Fh: wd_sel_2=1, write rt.
  - lw: MEM/WB mem_r=1; WB wd_sel_1=1.
  - sw: MEM mem_w=1, md_sel_1=0; no register write.
- Branches beq 04h / bne 05h:
  - op2_sel_4=1, sub.
  - `zero_q` captures `ZERO` at the EXE→MEM edge.
  - Taken when beq & zero_q or bne & !zero_q.
- Jumps: jmp 02h; jal 03h additionally writes R31 (wa_sel_2=1, wa_sel_3=0, wd_sel_3=0).
- Stack ops: all use op1_sel_1=1, op2_sel_3=1, op2_sel_1=0 (constant 1), ma_sel_1=1.
  - push 1Bh: r1_sel_1=1; MEM mem_w=1, md_sel_1=1; ALU sub; WB sp_load.
  - pop 1Ch: ALU add, sp_load in EXE; MEM/WB mem_r=1; WB writes R0 (wa_sel_3=0, wa_sel_2=0, wd_sel_1=1).
- Unknown opcode or funct: executes as NOP, with PC ← PC+1 only.
- pc_load=1 in WB for every instruction.

## Timing
- Reset (RST low, asynchronous): state=IF, `zero_q`=0, `STATE`=0. `CTRL` shows the IF pattern 0x08000030.
- Release: the first IF cycle completes on the first rising edge after RST goes high.
- One instruction per 5 cycles; the PC updates at the WB→IF edge.
- Register-file and SP writes occur at the same edge. jal's link value uses pc_plus_one from the pre-update PC.
- Reset asserted mid-instruction returns to IF immediately. No partial writes are issued afterwards.
- `ZERO` is sampled only at the EXE→MEM edge. `ZERO` glitches in other states have no effect.

## Test plan
- Reset: hold RST low, toggle CLK → STATE=0, CTRL=0x08000030. Release → STATE sequence 1,2,3,4,0.
- `add` (INSTRUCTION=0x00430820) → ID CTRL=0x00000100; WB CTRL=0x0060930B.
- `jmp` (0x08000010) → WB CTRL=0x00000101.
- `beq`: ZERO=1 at EXE → WB pc_sel_2=1, pc_sel_3=1. Repeat with ZERO=0 → pc_sel_1=1, pc_sel_2=0.
- `push` then `pop`: push MEM has mem_w=1, ma_sel_1=1, md_sel_1=1, r1_sel_1=1; push WB sp_load=1, alu_oprn=2. Pop EXE sp_load=1, alu_oprn=1; pop WB reg_w=1, wd_sel_1=1.
- Assert RST low during MEM of `sw` → mem_w drops combinationally, STATE=0, no WB state follows.

Source files
------------

// File: rtl/control_unit_if.sv
// Control-unit <-> data-path bundle: instruction/flag in, control word and state out.
interface control_unit_if;
  logic [31:0] INSTRUCTION;
  logic        ZERO;
  logic [31:0] CTRL;
  logic [2:0]  STATE;

  modport master (output INSTRUCTION, output ZERO, input CTRL, input STATE);
  modport slave  (input INSTRUCTION, input ZERO, output CTRL, output STATE);
endinterface

// File: rtl/control_unit.sv
// Five-state multi-cycle sequencer producing the data-path control word.
// state | meaning: IF fetch into IR | ID register read | EXE ALU op | MEM memory access | WB write-back, PC update
module control_unit (
  input  logic         CLK,
  input  logic         RST,
  control_unit_if.slave bus
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam logic [31:0] M_PC_LOAD  = 32'h0000_0001;
  localparam logic [31:0] M_PC_SEL_1 = 32'h0000_0002;
  localparam logic [31:0] M_PC_SEL_2 = 32'h0000_0004;
  localparam logic [31:0] M_PC_SEL_3 = 32'h0000_0008;
  localparam logic [31:0] M_IR_LOAD  = 32'h0000_0010;
  localparam logic [31:0] M_MEM_R    = 32'h0000_0020;
  localparam logic [31:0] M_MEM_W    = 32'h0000_0040;
  localparam logic [31:0] M_R1_SEL_1 = 32'h0000_0080;
  localparam logic [31:0] M_REG_R    = 32'h0000_0100;
  localparam logic [31:0] M_REG_W    = 32'h0000_0200;
  localparam logic [31:0] M_WA_SEL_1 = 32'h0000_0400;
  localparam logic [31:0] M_WA_SEL_2 = 32'h0000_0800;
  localparam logic [31:0] M_WA_SEL_3 = 32'h0000_1000;
  localparam logic [31:0] M_WD_SEL_1 = 32'h0000_2000;
  localparam logic [31:0] M_WD_SEL_2 = 32'h0000_4000;
  localparam logic [31:0] M_WD_SEL_3 = 32'h0000_8000;
  localparam logic [31:0] M_SP_LOAD  = 32'h0001_0000;
  localparam logic [31:0] M_OP1_SEL_1 = 32'h0002_0000;
  localparam logic [31:0] M_OP2_SEL_1 = 32'h0004_0000;
  localparam logic [31:0] M_OP2_SEL_2 = 32'h0008_0000;
  localparam logic [31:0] M_OP2_SEL_3 = 32'h0010_0000;
  localparam logic [31:0] M_OP2_SEL_4 = 32'h0020_0000;
  localparam logic [31:0] M_MA_SEL_1 = 32'h0400_0000;
  localparam logic [31:0] M_MA_SEL_2 = 32'h0800_0000;
  localparam logic [31:0] M_MD_SEL_1 = 32'h1000_0000;

  localparam logic [31:0] IF_CTRL  = M_MA_SEL_2 | M_MEM_R | M_IR_LOAD;
  localparam logic [31:0] WR_RD    = M_REG_W | M_WA_SEL_3 | M_WD_SEL_3;
  localparam logic [31:0] WR_RT    = M_REG_W | M_WA_SEL_3 | M_WA_SEL_1 | M_WD_SEL_3;
  localparam logic [31:0] STACK    = M_OP1_SEL_1 | M_OP2_SEL_3 | M_MA_SEL_1;
  localparam logic [31:0] PC_NORM  = M_PC_SEL_1 | M_PC_SEL_3;
  localparam logic [31:0] PC_JR    = M_PC_SEL_3;
  localparam logic [31:0] PC_TAKEN = M_PC_SEL_2 | M_PC_SEL_3;
  localparam logic [31:0] PC_JUMP  = 32'h0000_0000;

  state_t      r_state;
  state_t      w_next_state;
  logic        r_zero_q;
  logic [5:0]  w_opcode;
  logic [5:0]  w_funct;
  logic [3:0]  w_alu;
  logic [31:0] w_exe;
  logic [31:0] w_exe_only;
  logic [31:0] w_mem;
  logic [31:0] w_wb;
  logic [31:0] w_pc;
  logic [31:0] w_ctrl;
  logic [19:0] w_unused_fields;

  assign w_opcode        = bus.INSTRUCTION[31:26];
  assign w_funct         = bus.INSTRUCTION[5:0];
  assign w_unused_fields = bus.INSTRUCTION[25:6];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state  <= S_IF;
      r_zero_q <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_EXE) r_zero_q <= bus.ZERO;
    end
  end

  always_comb begin
    w_next_state = S_IF;
    case (r_state)
      S_IF:    w_next_state = S_ID;
      S_ID:    w_next_state = S_EXE;
      S_EXE:   w_next_state = S_MEM;
      S_MEM:   w_next_state = S_WB;
      default: w_next_state = S_IF;
    endcase
  end

  // Instruction decode: bits held from EXE onward, plus per-phase extras.
  always_comb begin
    w_alu      = 4'd0;
    w_exe      = 32'h0;
    w_exe_only = 32'h0;
    w_mem      = 32'h0;
    w_wb       = 32'h0;
    w_pc       = PC_NORM;
    case (w_opcode)
      6'h00: begin
        case (w_funct)
          6'h20: begin w_alu = 4'd1; w_exe = M_OP2_SEL_4; w_wb = WR_RD; end
          6'h22: begin w_alu = 4'd2; w_exe = M_OP2_SEL_4; w_wb = WR_RD; end
          6'h2C: begin w_alu = 4'd3; w_exe = M_OP2_SEL_4; w_wb = WR_RD; end
          6'h24: begin w_alu = 4'd6; w_exe = M_OP2_SEL_4; w_wb = WR_RD; end
          6'h25: begin w_alu = 4'd7; w_exe = M_OP2_SEL_4; w_wb = WR_RD; end
          6'h27: begin w_alu = 4'd8; w_exe = M_OP2_SEL_4; w_wb = WR_RD; end
          6'h2A: begin w_alu = 4'd9; w_exe = M_OP2_SEL_4; w_wb = WR_RD; end
          6'h01: begin w_alu = 4'd5; w_exe = M_OP2_SEL_3 | M_OP2_SEL_1; w_wb = WR_RD; end
          6'h02: begin w_alu = 4'd4; w_exe = M_OP2_SEL_3 | M_OP2_SEL_1; w_wb = WR_RD; end
          6'h08: w_pc = PC_JR;
          default: ;
        endcase
      end
      6'h08: begin w_alu = 4'd1; w_exe = M_OP2_SEL_2; w_wb = WR_RT; end
      6'h1D: begin w_alu = 4'd3; w_exe = M_OP2_SEL_2; w_wb = WR_RT; end
      6'h0A: begin w_alu = 4'd9; w_exe = M_OP2_SEL_2; w_wb = WR_RT; end
      6'h0C: begin w_alu = 4'd6; w_wb = WR_RT; end
      6'h0D: begin w_alu = 4'd7; w_wb = WR_RT; end
      6'h0F: w_wb = WR_RT | M_WD_SEL_2;
      6'h23: begin
        w_alu = 4'd1;
        w_exe = M_OP2_SEL_2;
        w_mem = M_MEM_R;
        w_wb  = WR_RT | M_MEM_R | M_WD_SEL_1;
      end
      6'h2B: begin w_alu = 4'd1; w_exe = M_OP2_SEL_2; w_mem = M_MEM_W; end
      6'h04: begin
        w_alu = 4'd2;
        w_exe = M_OP2_SEL_4;
        w_pc  = r_zero_q ? PC_TAKEN : PC_NORM;
      end
      6'h05: begin
        w_alu = 4'd2;
        w_exe = M_OP2_SEL_4;
        w_pc  = r_zero_q ? PC_NORM : PC_TAKEN;
      end
      6'h02: w_pc = PC_JUMP;
      6'h03: begin w_pc = PC_JUMP; w_wb = M_REG_W | M_WA_SEL_2; end
      6'h1B: begin
        w_alu = 4'd2;
        w_exe = STACK | M_R1_SEL_1;
        w_mem = M_MEM_W | M_MD_SEL_1;
        w_wb  = M_SP_LOAD;
      end
      6'h1C: begin
        w_alu      = 4'd1;
        w_exe      = STACK;
        w_exe_only = M_SP_LOAD;
        w_mem      = M_MEM_R;
        w_wb       = M_MEM_R | M_REG_W | M_WD_SEL_1;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_ctrl = IF_CTRL;
    case (r_state)
      S_IF:  w_ctrl = IF_CTRL;
      S_ID:  w_ctrl = M_REG_R;
      S_EXE: w_ctrl = M_REG_R | w_exe | {6'd0, w_alu, 22'd0} | w_exe_only;
      S_MEM: w_ctrl = M_REG_R | w_exe | {6'd0, w_alu, 22'd0} | w_mem;
      S_WB:  w_ctrl = M_REG_R | w_exe | {6'd0, w_alu, 22'd0} | w_wb | w_pc | M_PC_LOAD;
      default: w_ctrl = IF_CTRL;
    endcase
  end

  assign bus.CTRL  = w_ctrl;
  assign bus.STATE = r_state;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: fixed vectors, reset corner cases, random vs reference model.
module tb_control_unit;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  control_unit_if bus();

  control_unit dut (.CLK(CLK), .RST(RST), .bus(bus.slave));

  always #5 CLK = ~CLK;

  localparam logic [31:0] IF_PAT = 32'h0800_0030;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] ins;
    logic        z;
    logic [31:0] exe;
    logic [31:0] mem;
    logic [31:0] wb;
  } vec_t;

  vec_t vecs[17];

  int r_alu[int];
  int i_alu[int];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] bm(input int pos);
    logic [31:0] one = 32'h1;
    return one << pos;
  endfunction

  // Reference: per-instruction field lists assembled into the word by bit position.
  function automatic logic [31:0] model_ctrl(input int st, input logic [31:0] ins, input logic zq);
    int op = int'(ins[31:26]);
    int fn = int'(ins[5:0]);
    int alu = 0;
    int pc_kind = 0;
    logic [31:0] exe = 0, exe_only = 0, mem = 0, wb = 0, c;
    logic [31:0] wr_rd = bm(9) | bm(12) | bm(15);
    logic [31:0] wr_rt = bm(9) | bm(12) | bm(10) | bm(15);
    logic [31:0] stack = bm(17) | bm(20) | bm(26);
    if (op == 0 && r_alu.exists(fn)) begin
      alu = r_alu[fn]; exe = bm(21); wb = wr_rd;
    end else if (op == 0 && (fn == 1 || fn == 2)) begin
      alu = (fn == 1) ? 5 : 4; exe = bm(20) | bm(18); wb = wr_rd;
    end else if (op == 0 && fn == 8) begin
      pc_kind = 1;
    end else if (i_alu.exists(op)) begin
      alu = i_alu[op];
      if (op != 'h0C && op != 'h0D) exe = bm(19);
      if (op != 'h2B) wb = wr_rt;
      if (op == 'h23) begin mem = bm(5); wb |= bm(5) | bm(13); end
      if (op == 'h2B) mem = bm(6);
    end else if (op == 'h0F) begin
      wb = wr_rt | bm(14);
    end else if (op == 4 || op == 5) begin
      alu = 2; exe = bm(21);
      pc_kind = (((op == 4) && zq) || ((op == 5) && !zq)) ? 2 : 0;
    end else if (op == 2 || op == 3) begin
      pc_kind = 3;
      if (op == 3) wb = bm(9) | bm(11);
    end else if (op == 'h1B) begin
      alu = 2; exe = stack | bm(7); mem = bm(6) | bm(28); wb = bm(16);
    end else if (op == 'h1C) begin
      alu = 1; exe = stack; exe_only = bm(16); mem = bm(5); wb = bm(5) | bm(9) | bm(13);
    end
    exe |= 32'(alu) << 22;
    c = bm(8);
    case (st)
      0: c = IF_PAT;
      1: ;
      2: c |= exe | exe_only;
      3: c |= exe | mem;
      default: begin
        c |= exe | wb | bm(0);
        case (pc_kind)
          0: c |= bm(1) | bm(3);
          1: c |= bm(3);
          2: c |= bm(2) | bm(3);
          default: ;
        endcase
      end
    endcase
    return c;
  endfunction

  int ops[15] = '{'h00, 'h08, 'h1D, 'h0A, 'h0C, 'h0D, 'h0F, 'h23, 'h2B, 'h04, 'h05, 'h02, 'h03, 'h1B, 'h1C};
  int fns[10] = '{'h20, 'h22, 'h2C, 'h24, 'h25, 'h27, 'h2A, 'h01, 'h02, 'h08};

  initial begin
    logic [31:0] ins;
    logic        m_zq;
    int          m_st;

    r_alu['h20] = 1; r_alu['h22] = 2; r_alu['h2C] = 3; r_alu['h24] = 6;
    r_alu['h25] = 7; r_alu['h27] = 8; r_alu['h2A] = 9;
    i_alu['h08] = 1; i_alu['h1D] = 3; i_alu['h0A] = 9; i_alu['h23] = 1;
    i_alu['h2B] = 1; i_alu['h0C] = 6; i_alu['h0D] = 7;

    vecs[0]  = '{32'h0043_0820, 1'b0, 32'h0060_0100, 32'h0060_0100, 32'h0060_930B};
    vecs[1]  = '{32'h0002_0841, 1'b0, 32'h0154_0100, 32'h0154_0100, 32'h0154_930B};
    vecs[2]  = '{32'h03E0_0008, 1'b1, 32'h0000_0100, 32'h0000_0100, 32'h0000_0109};
    vecs[3]  = '{32'h2022_0004, 1'b0, 32'h0048_0100, 32'h0048_0100, 32'h0048_970B};
    vecs[4]  = '{32'h3022_0FF0, 1'b0, 32'h0180_0100, 32'h0180_0100, 32'h0180_970B};
    vecs[5]  = '{32'h3C01_1234, 1'b0, 32'h0000_0100, 32'h0000_0100, 32'h0000_D70B};
    vecs[6]  = '{32'h8C22_0004, 1'b0, 32'h0048_0100, 32'h0048_0120, 32'h0048_B72B};
    vecs[7]  = '{32'hAC22_0004, 1'b0, 32'h0048_0100, 32'h0048_0140, 32'h0048_010B};
    vecs[8]  = '{32'h1022_0003, 1'b1, 32'h00A0_0100, 32'h00A0_0100, 32'h00A0_010D};
    vecs[9]  = '{32'h1022_0003, 1'b0, 32'h00A0_0100, 32'h00A0_0100, 32'h00A0_010B};
    vecs[10] = '{32'h1422_0003, 1'b1, 32'h00A0_0100, 32'h00A0_0100, 32'h00A0_010B};
    vecs[11] = '{32'h0800_0010, 1'b0, 32'h0000_0100, 32'h0000_0100, 32'h0000_0101};
    vecs[12] = '{32'h0C00_0010, 1'b0, 32'h0000_0100, 32'h0000_0100, 32'h0000_0B01};
    vecs[13] = '{32'h6C00_0000, 1'b0, 32'h0492_0180, 32'h1492_01C0, 32'h0493_018B};
    vecs[14] = '{32'h7000_0000, 1'b0, 32'h0453_0100, 32'h0452_0120, 32'h0452_232B};
    vecs[15] = '{32'hFC00_0000, 1'b1, 32'h0000_0100, 32'h0000_0100, 32'h0000_010B};
    vecs[16] = '{32'h0000_003F, 1'b0, 32'h0000_0100, 32'h0000_0100, 32'h0000_010B};

    bus.INSTRUCTION = 32'h0043_0820;
    bus.ZERO        = 1'b0;

    // Reset held while clocking.
    repeat (3) begin
      @(negedge CLK);
      chk("reset_state", 32'(bus.STATE), 32'd0);
      chk("reset_ctrl", bus.CTRL, IF_PAT);
    end
    RST = 1'b1;
    for (int s = 1; s <= 5; s++) begin
      @(negedge CLK);
      chk("release_seq", 32'(bus.STATE), 32'(s % 5));
    end

    // Table vectors; ZERO toggled outside EXE to show only the EXE->MEM sample counts.
    for (int i = 0; i < 17; i++) begin
      bus.INSTRUCTION = vecs[i].ins;
      bus.ZERO = 1'($urandom);
      chk($sformatf("v%0d_if", i), bus.CTRL, IF_PAT);
      @(negedge CLK);
      chk($sformatf("v%0d_id", i), bus.CTRL, 32'h0000_0100);
      bus.ZERO = vecs[i].z;
      @(negedge CLK);
      chk($sformatf("v%0d_exe", i), bus.CTRL, vecs[i].exe);
      @(negedge CLK);
      chk($sformatf("v%0d_mem", i), bus.CTRL, vecs[i].mem);
      bus.ZERO = ~vecs[i].z;
      @(negedge CLK);
      chk($sformatf("v%0d_wb", i), bus.CTRL, vecs[i].wb);
      chk($sformatf("v%0d_wb_state", i), 32'(bus.STATE), 32'd4);
      bus.ZERO = 1'($urandom);
      @(negedge CLK);
    end

    // Reset during MEM of sw.
    bus.INSTRUCTION = 32'hAC22_0004;
    repeat (3) @(negedge CLK);
    chk("sw_mem_w_before_rst", 32'(bus.CTRL[6]), 32'd1);
    #2 RST = 1'b0;
    #1;
    chk("sw_rst_state", 32'(bus.STATE), 32'd0);
    chk("sw_rst_ctrl", bus.CTRL, IF_PAT);
    @(negedge CLK);
    chk("sw_rst_hold", 32'(bus.STATE), 32'd0);
    RST = 1'b1;
    for (int s = 1; s <= 5; s++) begin
      @(negedge CLK);
      chk("sw_restart_seq", 32'(bus.STATE), 32'(s % 5));
    end

    // Random instructions against the reference model.
    m_st = 0;
    m_zq = 1'b0;
    ins  = 32'h0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      if (m_st == 0) begin
        ins = $urandom;
        if ($urandom_range(0, 9) < 8) begin
          ins[31:26] = 6'(ops[$urandom_range(0, 14)]);
          if (ins[31:26] == 6'd0 && $urandom_range(0, 9) < 8) ins[5:0] = 6'(fns[$urandom_range(0, 9)]);
        end
        bus.INSTRUCTION = ins;
      end
      chk("rand_ctrl", bus.CTRL, model_ctrl(m_st, ins, m_zq));
      chk("rand_state", 32'(bus.STATE), 32'(m_st));
      bus.ZERO = 1'($urandom);
      if (m_st == 2) m_zq = bus.ZERO;
      m_st = (m_st + 1) % 5;
      @(negedge CLK);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
